// File: rtl/truth_sweep_pkg.sv
// Shared types and constants for the truth-table sweeper and its settle timer.
// The expected table encodes f = a&(b|c), bit i for {a,b,c} = i.
package truth_sweep_pkg;

   localparam int IDX_W = 3;
   localparam int CNT_W = 4;
   localparam int MIS_W = 4;

   localparam logic [7:0] FUNC_EXPECTED = 8'hE0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      FINISH = 2'd3
   } state_e;

endpackage : truth_sweep_pkg

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable up/down settle counter with clear; tc_o flags the terminal count
// (SETTLE_CYCLES-1 when counting up, zero when counting down).
module settle_timer
   import truth_sweep_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   input  logic             up_i,
   output logic             tc_o
);

   localparam logic [CNT_W-1:0] TERM_UP = CNT_W'(SETTLE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear beats load beats count.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i) begin
         if (up_i) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = up_i ? (cnt_q == TERM_UP) : (cnt_q == {CNT_W{1'b0}});

endmodule : settle_timer

// File: rtl/truth_table_sweeper.sv
// Drives {a,b,c} through 000..111, samples f_in after a settle delay per vector,
// and reports the captured truth table against EXPECTED with a start/done handshake.
module truth_table_sweeper
   import truth_sweep_pkg::*;
#(
   parameter int         SETTLE_CYCLES = 4,
   parameter logic [7:0] EXPECTED      = FUNC_EXPECTED
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             f_in,
   output logic             a,
   output logic             b,
   output logic             c,
   output logic             busy,
   output logic             done,
   output logic [7:0]       result,
   output logic [MIS_W-1:0] mismatch_cnt,
   output logic             pass
);

   state_e           state_q,  state_d;
   logic [IDX_W-1:0] idx_q,    idx_d;
   logic [2:0]       abc_q,    abc_d;
   logic [7:0]       result_q, result_d;
   logic [MIS_W-1:0] mis_q,    mis_d;
   logic             pass_q,   pass_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;

   logic tmr_clr_s;
   logic tmr_en_s;
   logic tmr_tc_s;

   settle_timer #(
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) u_settle_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (tmr_clr_s),
      .load_i     (1'b0),
      .load_val_i ({CNT_W{1'b0}}),
      .en_i       (tmr_en_s),
      .up_i       (1'b1),
      .tc_o       (tmr_tc_s)
   );

   // Sweep sequencing; start is refused during the done cycle even though IDLE is already active.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      abc_d     = abc_q;
      result_d  = result_q;
      mis_d     = mis_q;
      pass_d    = pass_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      tmr_clr_s = 1'b0;
      tmr_en_s  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !done_q) begin
               idx_d     = {IDX_W{1'b0}};
               abc_d     = 3'b000;
               tmr_clr_s = 1'b1;
               result_d  = 8'h00;
               mis_d     = {MIS_W{1'b0}};
               pass_d    = 1'b0;
               busy_d    = 1'b1;
               state_d   = SETTLE;
            end else begin
               state_d = IDLE;
            end
         end
         SETTLE: begin
            tmr_en_s = 1'b1;
            if (tmr_tc_s) begin
               state_d = SAMPLE;
            end else begin
               state_d = SETTLE;
            end
         end
         SAMPLE: begin
            result_d[idx_q] = f_in;
            if (f_in != EXPECTED[idx_q]) begin
               mis_d = mis_q + {{(MIS_W-1){1'b0}}, 1'b1};
            end else begin
               mis_d = mis_q;
            end
            if (idx_q == 3'd7) begin
               state_d = FINISH;
            end else begin
               idx_d     = idx_q + 3'd1;
               abc_d     = idx_q + 3'd1;
               tmr_clr_s = 1'b1;
               state_d   = SETTLE;
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (mis_q == {MIS_W{1'b0}});
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= {IDX_W{1'b0}};
         abc_q    <= 3'b000;
         result_q <= 8'h00;
         mis_q    <= {MIS_W{1'b0}};
         pass_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         abc_q    <= abc_d;
         result_q <= result_d;
         mis_q    <= mis_d;
         pass_q   <= pass_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign {a, b, c}    = abc_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign result       = result_q;
   assign mismatch_cnt = mis_q;
   assign pass         = pass_q;

endmodule : truth_table_sweeper

// File: tb/tb_truth_table_sweeper.sv
// Randomized self-checking bench: two sweepers (settle 4 and settle 1) driven from a
// table-based model of the function block, with noise on f_in outside sample edges.
module tb_truth_table_sweeper;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0, rst1, start0, start1, f0, f1;
   logic       a0, b0, c0, busy0, done0, pass0;
   logic       a1, b1, c1, busy1, done1, pass1;
   logic [7:0] res0, res1;
   logic [3:0] mis0, mis1;

   int n_cmp = 0;
   int n_bad = 0;

   truth_table_sweeper #(.SETTLE_CYCLES(4)) dut0 (
      .clk(clk), .rst_n(rst0), .start(start0), .f_in(f0),
      .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0),
      .result(res0), .mismatch_cnt(mis0), .pass(pass0)
   );

   truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst1), .start(start1), .f_in(f1),
      .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1),
      .result(res1), .mismatch_cnt(mis1), .pass(pass1)
   );

   // Truth table of f = a·b + a·b'·c + a·c, built index by index.
   function automatic logic [7:0] ref_table();
      logic [7:0] t;
      logic       fa, fb, fc;
      for (int i = 0; i < 8; i++) begin
         fa = ((i >> 2) & 1) != 0;
         fb = ((i >> 1) & 1) != 0;
         fc = (i & 1) != 0;
         t[i] = (fa & fb) | (fa & ~fb & fc) | (fa & fc);
      end
      return t;
   endfunction

   function automatic int popcnt(input logic [7:0] v);
      int n = 0;
      for (int i = 0; i < 8; i++) n += int'(v[i]);
      return n;
   endfunction

   task automatic drive(input int inst, input logic st, input logic fv);
      if (inst == 0) begin start0 = st; f0 = fv; end
      else           begin start1 = st; f1 = fv; end
   endtask

   function automatic logic [2:0] rd_abc(input int inst);
      return (inst == 0) ? {a0, b0, c0} : {a1, b1, c1};
   endfunction
   function automatic logic rd_busy(input int inst);
      return (inst == 0) ? busy0 : busy1;
   endfunction
   function automatic logic rd_done(input int inst);
      return (inst == 0) ? done0 : done1;
   endfunction
   function automatic logic rd_pass(input int inst);
      return (inst == 0) ? pass0 : pass1;
   endfunction
   function automatic logic [7:0] rd_res(input int inst);
      return (inst == 0) ? res0 : res1;
   endfunction
   function automatic logic [3:0] rd_mis(input int inst);
      return (inst == 0) ? mis0 : mis1;
   endfunction

   // One full sweep; j counts edges after the start-accept edge k.
   task automatic run_sweep(input int inst, input logic [7:0] tbl, input bit noise,
                            input bit extra_starts, input bit probe_done, input string tag);
      int         s       = (inst == 0) ? 4 : 1;
      int         lat     = 8 * (s + 1) + 1;
      int         exp_mis = popcnt(tbl ^ ref_table());
      logic       exp_pass = (exp_mis == 0);
      int         idx;
      logic [2:0] exp_abc;
      logic       fv, st;
      @(negedge clk);
      drive(inst, 1'b1, tbl[0]);
      @(posedge clk);
      for (int j = 0; j <= lat; j++) begin
         @(negedge clk);
         idx = j / (s + 1);
         if (idx > 7) idx = 7;
         exp_abc = 3'(idx);
         n_cmp++;
         if (rd_abc(inst) !== exp_abc) begin
            n_bad++;
            $display("FAIL %s abc edge k+%0d: got %0d want %0d", tag, j, rd_abc(inst), exp_abc);
         end
         n_cmp++;
         if (rd_busy(inst) !== (j < lat)) begin
            n_bad++;
            $display("FAIL %s busy edge k+%0d: got %b want %b", tag, j, rd_busy(inst), (j < lat));
         end
         n_cmp++;
         if (rd_done(inst) !== (j == lat)) begin
            n_bad++;
            $display("FAIL %s done edge k+%0d: got %b want %b", tag, j, rd_done(inst), (j == lat));
         end
         if (j == lat) begin
            n_cmp++;
            if (rd_res(inst) !== tbl) begin
               n_bad++;
               $display("FAIL %s result: got %h want %h", tag, rd_res(inst), tbl);
            end
            n_cmp++;
            if (rd_mis(inst) !== 4'(exp_mis)) begin
               n_bad++;
               $display("FAIL %s mismatch_cnt: got %0d want %0d", tag, rd_mis(inst), exp_mis);
            end
            n_cmp++;
            if (rd_pass(inst) !== exp_pass) begin
               n_bad++;
               $display("FAIL %s pass: got %b want %b", tag, rd_pass(inst), exp_pass);
            end
         end
         fv = tbl[idx];
         if (noise && ((j % (s + 1)) != s)) fv = logic'($urandom_range(0, 1));
         st = (extra_starts && (j == 9 || j == 19)) || (probe_done && j == lat);
         drive(inst, st, fv);
      end
      if (probe_done) begin
         @(negedge clk);
         n_cmp++;
         if (rd_busy(inst) !== 1'b0 || rd_done(inst) !== 1'b0) begin
            n_bad++;
            $display("FAIL %s start-in-done-cycle: got busy=%b done=%b want 0 0",
                     tag, rd_busy(inst), rd_done(inst));
         end
         n_cmp++;
         if (rd_pass(inst) !== exp_pass || rd_res(inst) !== tbl) begin
            n_bad++;
            $display("FAIL %s hold after done: got pass=%b result=%h want %b %h",
                     tag, rd_pass(inst), rd_res(inst), exp_pass, tbl);
         end
         drive(inst, 1'b0, 1'b0);
      end
   endtask

   task automatic test_reset();
      rst0 = 1'b0; rst1 = 1'b0;
      start0 = 1'b0; start1 = 1'b0; f0 = 1'b0; f1 = 1'b0;
      #12;
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (rd_abc(i) !== 3'b000 || rd_busy(i) !== 1'b0 || rd_done(i) !== 1'b0 ||
             rd_res(i) !== 8'h00 || rd_mis(i) !== 4'd0 || rd_pass(i) !== 1'b0) begin
            n_bad++;
            $display("FAIL reset inst%0d: got abc=%0d busy=%b done=%b res=%h mis=%0d pass=%b want all 0",
                     i, rd_abc(i), rd_busy(i), rd_done(i), rd_res(i), rd_mis(i), rd_pass(i));
         end
      end
      @(negedge clk);
      rst0 = 1'b1; rst1 = 1'b1;
   endtask

   task automatic test_model();
      run_sweep(0, ref_table(), 1'b0, 1'b0, 1'b0, "model");
   endtask

   task automatic test_stuck();
      run_sweep(0, 8'h00, 1'b0, 1'b0, 1'b0, "stuck0");
      run_sweep(0, 8'hFF, 1'b0, 1'b0, 1'b0, "stuck1");
   endtask

   task automatic test_inverted();
      run_sweep(0, ~ref_table(), 1'b0, 1'b0, 1'b0, "inverted");
   endtask

   task automatic test_start_ignored();
      run_sweep(0, ref_table(), 1'b0, 1'b1, 1'b1, "restart_ignored");
   endtask

   // Abort a sweep with a stuck-1 block while abc=011, then sweep the good model.
   task automatic test_reset_mid();
      @(negedge clk);
      drive(0, 1'b1, 1'b1);
      @(posedge clk);
      for (int j = 0; j < 15; j++) begin
         @(negedge clk);
         drive(0, 1'b0, 1'b1);
      end
      @(negedge clk);
      n_cmp++;
      if (rd_abc(0) !== 3'b011 || res0 !== 8'h07 || mis0 !== 4'd3) begin
         n_bad++;
         $display("FAIL mid_sweep_state: got abc=%0d res=%h mis=%0d want 3 07 3", rd_abc(0), res0, mis0);
      end
      #1 rst0 = 1'b0;
      #1;
      n_cmp++;
      if (rd_abc(0) !== 3'b000 || busy0 !== 1'b0 || done0 !== 1'b0 ||
          res0 !== 8'h00 || mis0 !== 4'd0 || pass0 !== 1'b0) begin
         n_bad++;
         $display("FAIL async_reset: got abc=%0d busy=%b done=%b res=%h mis=%0d pass=%b want all 0",
                  rd_abc(0), busy0, done0, res0, mis0, pass0);
      end
      @(negedge clk);
      rst0 = 1'b1;
      run_sweep(0, ref_table(), 1'b0, 1'b0, 1'b0, "after_reset");
   endtask

   task automatic test_settle1();
      run_sweep(1, ref_table(), 1'b1, 1'b0, 1'b1, "settle1");
   endtask

   task automatic test_random();
      int         inst;
      logic [7:0] tbl;
      for (int r = 0; r < 6; r++) begin
         inst = int'($urandom_range(0, 1));
         tbl  = 8'($urandom);
         run_sweep(inst, tbl, 1'b1, 1'b0, 1'b0, "random");
      end
   endtask

   initial begin
      test_reset();
      test_model();
      test_stuck();
      test_inverted();
      test_start_ignored();
      test_reset_mid();
      test_settle1();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_truth_table_sweeper

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Upstream stimulus and capture stage for the 3-input gate-level function block, which computes f = a·b + a·b'·c + a·c. The sweeper drives its a, b and c inputs through all 8 combinations in binary order, with index {a,b,c}. It waits a programmable settle time for the gate delays, samples f, and accumulates an 8-bit truth table. It compares that table against an expected constant and reports pass/fail with a start/done handshake, so lab boards and benches can self-check the combinational block.

Parameters:
SETTLE_CYCLES, 4, clock cycles abc is held before f is sampled; legal range 1..15; must exceed the worst-case gate-path delay.
EXPECTED, 8'hE0, expected f per index (bit i = f for {a,b,c}=i); 8'hE0 is a·(b|c).

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a sweep; sampled only in IDLE
f_in  in  1  output f of the function block under test
a  out  1  stimulus bit 2 of index
b  out  1  stimulus bit 1 of index
c  out  1  stimulus bit 0 of index
busy  out  1  high from the start-accept edge until done
done  out  1  one-cycle pulse when the sweep completes
result  out  8  captured truth table, bit i = sampled f for index i
mismatch_cnt  out  4  number of indices where result != EXPECTED (0..8)
pass  out  1  high after done iff mismatch_cnt == 0; held until next start

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- All outputs are registered.
- Reset values: a=b=c=0, busy=0, done=0, result=8'h00, mismatch_cnt=0, pass=0, FSM=IDLE, idx=0, settle count=0.
- FSM states: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE: on an edge with start=1:
  - idx<=0, {a,b,c}<=3'b000, cnt<=0;
  - result<=0, mismatch_cnt<=0, pass<=0, busy<=1;
  - go to SETTLE.
  - With start=0, all outputs hold (result/pass/mismatch_cnt keep the last sweep).
- SETTLE: cnt increments each edge. On the edge where cnt==SETTLE_CYCLES-1, go to SAMPLE. abc stays stable throughout.
- SAMPLE (one edge):
  - result[idx]<=f_in.
  - If f_in != EXPECTED[idx], mismatch_cnt<=mismatch_cnt+1.
  - If idx==7, go to FINISH and leave abc at 3'b111.
  - Otherwise idx<=idx+1, {a,b,c}<=idx+1, cnt<=0, go to SETTLE.
- FINISH (one edge): done<=1, busy<=0, pass<=(final mismatch_cnt==0), go to IDLE. done clears on the following edge.
- Latency: start accepted at edge k. Each vector takes SETTLE_CYCLES+1 edges. done is high for the single cycle after edge k+8·(SETTLE_CYCLES+1)+1. For the default this is edge k+41.
- The mismatch_cnt update in the final SAMPLE must be visible to the pass computation in FINISH (no off-by-one). pass is computed from the registered count.
- start while busy=1, or during the done cycle, is ignored. A new sweep may start on the edge after done is deasserted, i.e. when IDLE is re-entered.
- idx is 3 bits. There is no wrap because the sweep ends at idx 7. mismatch_cnt saturates naturally at 8 and needs no overflow handling.
- f_in is sampled raw (no synchroniser). The block under test is driven only by this block's registered outputs, so it shares clk timing.
- Reset mid-sweep: everything returns immediately to the reset values, including abc=000. A partial result is discarded.

Decomposition:
- Shared package truth_sweep_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, FINISH);
  - the constant FUNC_EXPECTED = 8'hE0;
  - the width constants IDX_W=3, CNT_W=4.
- One sub-module, settle_timer: a loadable down/up counter with clear and a terminal-count flag, parameterised by SETTLE_CYCLES. The FSM stays in the top module.

Test Plan:
1. Reset, then start with f_in from a reference model a&(b|c) and SETTLE_CYCLES=4 -> abc steps through 000..111, done 41 edges after start, result=8'hE0, mismatch_cnt=0, pass=1.
2. f_in stuck at 0 -> result=8'h00, mismatch_cnt=3, pass=0; stuck at 1 -> result=8'hFF, mismatch_cnt=5, pass=0.
3. f_in = inverted model -> result=8'h1F, mismatch_cnt=8, pass=0.
4. Pulse start again at edges k+10 and k+20 during a sweep -> no restart, done still at k+41, and the same result as scenario 1.
5. Assert rst_n=0 while abc=011 -> all outputs return to reset values asynchronously; after release, a fresh start completes with result=8'hE0.
6. SETTLE_CYCLES=1 -> done at k+17 with result=8'hE0. Check that abc changes exactly every 2 edges and that f_in is sampled only on SAMPLE edges.
